// File: rtl/ysyx_22050133_lsu_pkg.sv
// LSU AXI master shared definitions: FSM states, transfer size codes, AXI constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_22050133_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4,
    ST_RSP  = 3'd5
  } lsu_state_e;

  // log2(bytes) encoding of LSU access size, identical to AXI AxSIZE
  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

endpackage

// File: rtl/ysyx_22050133_lsu_axi_master_if.sv
// Data-side AXI4 subset between the LSU master and the arbiter s2 port (no resp/id fields).
// Latency: n/a (wires only).
// Backpressure: standard valid/ready on every channel.
interface ysyx_22050133_lsu_axi_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                    aw_ready;
  logic                    aw_valid;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;

  logic                    w_ready;
  logic                    w_valid;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;

  logic                    b_ready;
  logic                    b_valid;

  logic                    ar_ready;
  logic                    ar_valid;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;

  logic                    r_ready;
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_data;

  modport master (
    input  aw_ready, output aw_valid, aw_addr, aw_len, aw_size, aw_burst,
    input  w_ready,  output w_valid, w_data, w_strb, w_last,
    output b_ready,  input  b_valid,
    input  ar_ready, output ar_valid, ar_addr, ar_len, ar_size, ar_burst,
    output r_ready,  input  r_valid, r_data
  );

  modport slave (
    output aw_ready, input  aw_valid, aw_addr, aw_len, aw_size, aw_burst,
    output w_ready,  input  w_valid, w_data, w_strb, w_last,
    input  b_ready,  output b_valid,
    output ar_ready, input  ar_valid, ar_addr, ar_len, ar_size, ar_burst,
    input  r_ready,  output r_valid, r_data
  );

endinterface

// File: rtl/ysyx_22050133_lsu_align.sv
// Byte-lane alignment: store strobe/data shift, misalign detect, load extract and sign/zero extend.
// Latency: purely combinational.
// Backpressure: none.
module ysyx_22050133_lsu_align
  import ysyx_22050133_lsu_pkg::*;
(
  input  logic [2:0]  st_size,
  input  logic [2:0]  st_off,
  input  logic [63:0] st_wdata,
  output logic [7:0]  st_strb,
  output logic [63:0] st_data,
  output logic        st_misalign,
  input  logic [2:0]  ld_size,
  input  logic [2:0]  ld_off,
  input  logic        ld_signed,
  input  logic [63:0] ld_raw,
  output logic [63:0] ld_data
);

  logic [7:0]  strb_base;
  logic [63:0] ld_shift;

  // Request side: base strobe per size, natural-alignment check, shift into the addressed lanes
  always_comb begin
    strb_base   = 8'h00;
    st_misalign = 1'b0;
    case (st_size)
      SIZE_B: strb_base = 8'h01;
      SIZE_H: begin strb_base = 8'h03; st_misalign = st_off[0];    end
      SIZE_W: begin strb_base = 8'h0F; st_misalign = |st_off[1:0]; end
      SIZE_D: begin strb_base = 8'hFF; st_misalign = |st_off;      end
      default: st_misalign = 1'b1;  // sizes 4..7 are illegal
    endcase
    st_strb = strb_base << st_off;
    st_data = st_wdata << {st_off, 3'b000};
  end

  // Response side: bring the addressed lanes down to bit 0, then extend from the top kept bit
  always_comb begin
    ld_shift = ld_raw >> {ld_off, 3'b000};
    ld_data  = '0;
    case (ld_size)
      SIZE_B: ld_data = {{56{ld_signed & ld_shift[7]}},  ld_shift[7:0]};
      SIZE_H: ld_data = {{48{ld_signed & ld_shift[15]}}, ld_shift[15:0]};
      SIZE_W: ld_data = {{32{ld_signed & ld_shift[31]}}, ld_shift[31:0]};
      SIZE_D: ld_data = ld_shift;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22050133_lsu_axi_master.sv
// Turns one LSU load/store into a single-beat AXI4 read or write; misaligned requests answer without bus traffic.
// Latency: accept T, rsp_valid at T+3 with ready slaves; T+1 when misaligned.
// Backpressure: one request in flight; req_ready low from accept until the response is consumed.
module ysyx_22050133_lsu_axi_master
  import ysyx_22050133_lsu_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_wen_i,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2:0]                req_size_i,
  input  logic                      req_signed_i,
  input  logic [AXI_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [AXI_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_misalign_o,
  ysyx_22050133_lsu_axi_master_if.master axi
);

  lsu_state_e state, state_nxt;

  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [2:0]                size_q;
  logic                      signed_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [7:0]                wstrb_q;
  logic                      misalign_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic                      aw_done, w_done;

  logic [7:0]                st_strb;
  logic [AXI_DATA_WIDTH-1:0] st_data, ld_data;
  logic                      st_misalign;
  logic                      accept, aw_hs, w_hs, r_hs;

  ysyx_22050133_lsu_align u_align (
    .st_size     (req_size_i),
    .st_off      (req_addr_i[2:0]),
    .st_wdata    (req_wdata_i),
    .st_strb     (st_strb),
    .st_data     (st_data),
    .st_misalign (st_misalign),
    .ld_size     (size_q),
    .ld_off      (addr_q[2:0]),
    .ld_signed   (signed_q),
    .ld_raw      (axi.r_data),
    .ld_data     (ld_data)
  );

  // Handshakes decoded from registered state so valids never depend on readies
  assign accept = (state == ST_IDLE) && req_valid_i;
  assign aw_hs  = (state == ST_AW_W) && !aw_done && axi.aw_ready;
  assign w_hs   = (state == ST_AW_W) && !w_done  && axi.w_ready;
  assign r_hs   = (state == ST_R)    && axi.r_valid;

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-state channel controls
  always_comb begin
    state_nxt    = state;
    req_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    axi.ar_valid = 1'b0;
    axi.aw_valid = 1'b0;
    axi.w_valid  = 1'b0;
    axi.b_ready  = 1'b0;
    axi.r_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (st_misalign)    state_nxt = ST_RSP;
          else if (req_wen_i) state_nxt = ST_AW_W;
          else                state_nxt = ST_AR;
        end
      end
      ST_AR: begin
        axi.ar_valid = 1'b1;
        if (axi.ar_ready) state_nxt = ST_R;
      end
      ST_R: begin
        axi.r_ready = 1'b1;
        if (axi.r_valid) state_nxt = ST_RSP;
      end
      ST_AW_W: begin
        // address and data channels retire independently, in any order
        axi.aw_valid = !aw_done;
        axi.w_valid  = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = ST_B;
      end
      ST_B: begin
        axi.b_ready = 1'b1;
        if (axi.b_valid) state_nxt = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, channel-done flags and response data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr_i;
        size_q     <= req_size_i;
        signed_q   <= req_signed_i;
        wdata_q    <= st_data;
        wstrb_q    <= st_strb;
        misalign_q <= st_misalign;
        rdata_q    <= '0;  // stores and errors answer with zero
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (r_hs)  rdata_q <= ld_data;
    end
  end

  assign rsp_rdata_o    = rdata_q;
  assign rsp_misalign_o = misalign_q;

  assign axi.ar_addr  = addr_q;
  assign axi.ar_len   = AXI_LEN_SINGLE;
  assign axi.ar_size  = size_q;
  assign axi.ar_burst = AXI_BURST_INCR;
  assign axi.aw_addr  = addr_q;
  assign axi.aw_len   = AXI_LEN_SINGLE;
  assign axi.aw_size  = size_q;
  assign axi.aw_burst = AXI_BURST_INCR;
  assign axi.w_data   = wdata_q;
  assign axi.w_strb   = wstrb_q;
  assign axi.w_last   = 1'b1;

endmodule

// File: tb/tb_ysyx_22050133_lsu_axi_master.sv
// Self-checking bench: AXI slave model with per-channel ready delays, scoreboard of expected responses.
// Latency: checks T+3 for ready slaves, T+1 for misaligned requests.
// Backpressure: exercises held responses and late aw_ready.
module tb_ysyx_22050133_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_misalign;

  always #5 clk = ~clk;

  ysyx_22050133_lsu_axi_master_if axi ();

  ysyx_22050133_lsu_axi_master dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_wen_i      (req_wen),
    .req_addr_i     (req_addr),
    .req_size_i     (req_size),
    .req_signed_i   (req_signed),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_misalign_o (rsp_misalign),
    .axi            (axi)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [64:0] sb_q[$];  // {misalign, rdata}

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- AXI slave model ----------------
  int          ar_dly = 0, aw_dly = 0, w_dly = 0;
  logic [63:0] rdata_cfg = '0;
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  int          n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, n_arv = 0, n_awv = 0;
  bit          aw_got = 0, w_got = 0, w_before_aw = 0;
  logic        pv_ar = 0, pr_ar = 0, pv_aw = 0, pr_aw = 0, pv_w = 0, pr_w = 0;
  logic        pv_r = 0, pr_r = 0, pv_b = 0, pr_b = 0;
  logic [31:0] last_ar_addr = '0, last_aw_addr = '0;
  logic [2:0]  last_ar_size = '0, last_aw_size = '0;
  logic [7:0]  last_ar_len = '0, last_aw_len = '0;
  logic [1:0]  last_ar_burst = '0;
  logic [63:0] last_w_data = '0;
  logic [7:0]  last_w_strb = '0;
  logic        last_w_last = 1'b0;

  initial begin
    axi.aw_ready = 1'b0;
    axi.w_ready  = 1'b0;
    axi.b_valid  = 1'b0;
    axi.ar_ready = 1'b0;
    axi.r_valid  = 1'b0;
    axi.r_data   = '0;
    forever begin
      @(negedge clk);
      // handshakes completed on the posedge just passed
      if (pv_r && pr_r) axi.r_valid = 1'b0;
      if (pv_ar && pr_ar) begin n_ar++; axi.r_valid = 1'b1; axi.r_data = rdata_cfg; end
      if (pv_b && pr_b) begin n_b++; axi.b_valid = 1'b0; end
      if (pv_aw && pr_aw) begin n_aw++; aw_got = 1; end
      if (pv_w && pr_w) begin n_w++; w_got = 1; end
      if (aw_got && w_got) begin axi.b_valid = 1'b1; aw_got = 0; w_got = 0; end
      if (rst) begin axi.r_valid = 1'b0; axi.b_valid = 1'b0; aw_got = 0; w_got = 0; end
      // observe outgoing channels
      if (axi.aw_valid && !axi.w_valid) w_before_aw = 1;
      if (axi.ar_valid) begin
        n_arv++;
        last_ar_addr = axi.ar_addr; last_ar_size = axi.ar_size;
        last_ar_len = axi.ar_len;   last_ar_burst = axi.ar_burst;
      end
      if (axi.aw_valid) begin
        n_awv++;
        last_aw_addr = axi.aw_addr; last_aw_size = axi.aw_size; last_aw_len = axi.aw_len;
      end
      if (axi.w_valid) begin
        last_w_data = axi.w_data; last_w_strb = axi.w_strb; last_w_last = axi.w_last;
      end
      // ready after a configurable number of cycles of valid
      ar_cnt = axi.ar_valid ? ar_cnt + 1 : 0;
      aw_cnt = axi.aw_valid ? aw_cnt + 1 : 0;
      w_cnt  = axi.w_valid  ? w_cnt + 1  : 0;
      axi.ar_ready = (ar_cnt > ar_dly);
      axi.aw_ready = (aw_cnt > aw_dly);
      axi.w_ready  = (w_cnt > w_dly);
      pv_ar = axi.ar_valid; pr_ar = axi.ar_ready;
      pv_aw = axi.aw_valid; pr_aw = axi.aw_ready;
      pv_w  = axi.w_valid;  pr_w  = axi.w_ready;
      pv_r  = axi.r_valid;  pr_r  = axi.r_ready;
      pv_b  = axi.b_valid;  pr_b  = axi.b_ready;
    end
  end

  // ---------------- request driver / response checker ----------------
  task automatic run_req(input string tag, input logic wen, input logic [31:0] addr,
                         input logic [2:0] size, input logic sgn, input logic [63:0] wdata,
                         input logic [63:0] exp_rd, input logic exp_mis,
                         input int exp_lat, input int hold);
    int          lat;
    bit          got;
    logic [64:0] e;
    sb_q.push_back({exp_mis, exp_rd});
    @(negedge clk);
    rsp_ready = (hold == 0);
    chk({tag, "_req_rdy"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr;
    req_size = size; req_signed = sgn; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 0; lat = 0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; lat = c; end
    end
    if (!got) begin
      chk({tag, "_timeout"}, 64'(rsp_valid), 64'd1);
      void'(sb_q.pop_front());
      rsp_ready = 1'b1;
      return;
    end
    e = sb_q.pop_front();
    if (exp_lat > 0) chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      chk({tag, "_hold_vld"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_hold_rdy"}, 64'(req_ready), 64'd0);
      chk({tag, "_hold_dat"}, rsp_rdata, e[63:0]);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    chk({tag, "_rdata"}, rsp_rdata, e[63:0]);
    chk({tag, "_mis"}, 64'(rsp_misalign), 64'(e[64]));
    @(posedge clk); #1;
  endtask

  int s_ar, s_aw, s_w, s_b, s_arv, s_awv;

  task automatic snap();
    s_ar = n_ar; s_aw = n_aw; s_w = n_w; s_b = n_b; s_arv = n_arv; s_awv = n_awv;
    w_before_aw = 0;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_rdy",  64'(req_ready),    64'd1);
    chk("rst_rsp_vld",  64'(rsp_valid),    64'd0);
    chk("rst_mis",      64'(rsp_misalign), 64'd0);
    chk("rst_rdata",    rsp_rdata,         64'd0);
    chk("rst_ar_vld",   64'(axi.ar_valid), 64'd0);
    chk("rst_aw_vld",   64'(axi.aw_valid), 64'd0);
    chk("rst_w_vld",    64'(axi.w_valid),  64'd0);
    chk("rst_rb_rdy",   64'({axi.r_ready, axi.b_ready}), 64'd0);
    rst = 1'b0;

    // doubleword load
    rdata_cfg = 64'h1122_3344_5566_7788;
    run_req("ld", 1'b0, 32'h8000_0008, 3'd3, 1'b0, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 3, 0);
    chk("ld_ar_addr",  64'(last_ar_addr),  64'h8000_0008);
    chk("ld_ar_size",  64'(last_ar_size),  64'd3);
    chk("ld_ar_len",   64'(last_ar_len),   64'd0);
    chk("ld_ar_burst", 64'(last_ar_burst), 64'd1);

    // sub-word loads with sign/zero extension
    rdata_cfg = 64'h1122_3344_8066_7788;
    run_req("lb_s", 1'b0, 32'h8000_0003, 3'd0, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3, 0);
    run_req("lbu",  1'b0, 32'h8000_0003, 3'd0, 1'b0, 64'd0, 64'h0000_0000_0000_0080, 1'b0, 3, 0);
    run_req("lh_s", 1'b0, 32'h8000_0006, 3'd1, 1'b1, 64'd0, 64'h0000_0000_0000_1122, 1'b0, 3, 0);
    rdata_cfg = 64'h8899_AABB_0000_0000;
    run_req("lw_s", 1'b0, 32'h8000_0004, 3'd2, 1'b1, 64'd0, 64'hFFFF_FFFF_8899_AABB, 1'b0, 3, 0);
    run_req("lwu",  1'b0, 32'h8000_0004, 3'd2, 1'b0, 64'd0, 64'h0000_0000_8899_AABB, 1'b0, 3, 0);

    // halfword store in the top lanes
    snap();
    run_req("sh", 1'b1, 32'h8000_0006, 3'd1, 1'b0, 64'h0000_0000_0000_BEEF, 64'd0, 1'b0, 3, 0);
    chk("sh_strb",    64'(last_w_strb),  64'h00C0);
    chk("sh_wdata",   last_w_data,       64'hBEEF_0000_0000_0000);
    chk("sh_wlast",   64'(last_w_last),  64'd1);
    chk("sh_aw_addr", 64'(last_aw_addr), 64'h8000_0006);
    chk("sh_aw_size", 64'(last_aw_size), 64'd1);
    chk("sh_aw_len",  64'(last_aw_len),  64'd0);
    chk("sh_b_cnt",   64'(n_b - s_b),    64'd1);
    chk("sh_no_ar",   64'(n_arv - s_arv), 64'd0);

    // byte store at odd lane
    run_req("sb", 1'b1, 32'h8000_0005, 3'd0, 1'b0, 64'h0000_0000_0000_00A5, 64'd0, 1'b0, 3, 0);
    chk("sb_strb",  64'(last_w_strb), 64'h0020);
    chk("sb_wdata", last_w_data,      64'h0000_A500_0000_0000);

    // word store with aw_ready three cycles late
    aw_dly = 3;
    snap();
    run_req("sw", 1'b1, 32'h8000_0010, 3'd2, 1'b0, 64'h0000_0000_DEAD_BEEF, 64'd0, 1'b0, 0, 0);
    chk("sw_w_first", 64'(w_before_aw),  64'd1);
    chk("sw_aw_cnt",  64'(n_aw - s_aw),  64'd1);
    chk("sw_w_cnt",   64'(n_w - s_w),    64'd1);
    chk("sw_b_cnt",   64'(n_b - s_b),    64'd1);
    chk("sw_strb",    64'(last_w_strb),  64'h000F);
    chk("sw_wdata",   last_w_data,       64'h0000_0000_DEAD_BEEF);
    aw_dly = 0;

    // misaligned and illegal-size requests: answered at T+1, no bus traffic
    snap();
    run_req("lw_mis", 1'b0, 32'h8000_0002, 3'd2, 1'b1, 64'd0, 64'd0, 1'b1, 1, 0);
    run_req("sh_mis", 1'b1, 32'h8000_0001, 3'd1, 1'b0, 64'hFFFF, 64'd0, 1'b1, 1, 0);
    run_req("sz4",    1'b0, 32'h8000_0000, 3'd4, 1'b0, 64'd0, 64'd0, 1'b1, 1, 0);
    chk("mis_no_ar", 64'(n_arv - s_arv), 64'd0);
    chk("mis_no_aw", 64'(n_awv - s_awv), 64'd0);

    // response held for 5 cycles
    rdata_cfg = 64'hCAFE_F00D_0123_4567;
    run_req("ld_hold", 1'b0, 32'h8000_0000, 3'd3, 1'b0, 64'd0, 64'hCAFE_F00D_0123_4567, 1'b0, 3, 5);

    // reset in the middle of a stalled read address phase
    ar_dly = 10;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0020; req_size = 3'd3; req_signed = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_ar_vld", 64'(axi.ar_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ar_drop", 64'(axi.ar_valid), 64'd0);
    chk("rst_mid_idle",    64'(req_ready),    64'd1);
    chk("rst_mid_rsp",     64'(rsp_valid),    64'd0);
    rst = 1'b0;
    ar_dly = 0;

    // recovery after reset
    rdata_cfg = 64'h0F0E_0D0C_0B0A_0908;
    run_req("ld_after_rst", 1'b0, 32'h8000_0008, 3'd3, 1'b0, 64'd0, 64'h0F0E_0D0C_0B0A_0908, 1'b0, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
